// File: rtl/nab_pkg.sv
// -----------------------------------------------------------------------------
// nab_pkg
// Types and helpers shared by the network readout/vote blocks.
//   class_t        : 2-bit class index
//   NUM_CLASSES    : number of classes that the readout stage can emit
//   vote_state_t   : ACCUM/DECIDE states of the vote filter
//   clog2()        : constant ceil(log2) used to size counters
// -----------------------------------------------------------------------------
package nab_pkg;

  localparam int NUM_CLASSES = 4;

  typedef logic [1:0] class_t;

  typedef enum logic {
    ACCUM  = 1'b0,
    DECIDE = 1'b1
  } vote_state_t;

  // ceil(log2(value)); clog2(9) = 4, so a 0..8 counter fits in clog2(8+1) bits.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage : nab_pkg

// File: rtl/vote_argmax.sv
// -----------------------------------------------------------------------------
// vote_argmax
// Combinational argmax over NUM_CLASSES vote counters. On a tie the lowest
// index wins. Shared with the readout stage.
// Ports:
//   i_vote  : packed vote counters, element i is the count for class i
//   o_idx   : winning class index
//   o_count : vote count of the winning class
// -----------------------------------------------------------------------------
module vote_argmax
  import nab_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [NUM_CLASSES-1:0][CW-1:0] i_vote,
  output class_t                         o_idx,
  output logic [CW-1:0]                  o_count
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    o_idx   = '0;
    o_count = i_vote[0];
    // Strict '>' keeps the earlier (lower) index when counts are equal.
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (i_vote[i] > o_count) begin
        o_idx   = class_t'(i);
        o_count = i_vote[i];
      end
    end
  end

endmodule : vote_argmax

// File: rtl/network_output_vote.sv
// -----------------------------------------------------------------------------
// network_output_vote
// Majority-vote filter after the XADC readout. Counts per-sweep winner classes
// over WINDOW sweeps, then publishes a debounced class with a one-cycle valid.
// Optional feature macro: VOTE_HYST_EN -- when defined, a new class must win
// HOLD_WINDOWS consecutive confident windows before class_out moves.
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous reset, active low
//   network_output : per-sweep class index, valid with sweep_strobe
//   sweep_strobe   : one-cycle sweep pulse
//   class_out      : filtered class (reset 0)
//   class_valid    : one-cycle pulse per window decision
//   class_changed  : pulse with class_valid when class_out took a new value
//   low_conf       : pulse with class_valid when winner count < MIN_VOTES
//   win_count      : winner count of the last decision, held
// -----------------------------------------------------------------------------
module network_output_vote
  import nab_pkg::*;
#(
  parameter int unsigned WINDOW       = 8,
  parameter int unsigned MIN_VOTES    = 5,
  parameter int unsigned HOLD_WINDOWS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  class_t                        network_output,
  input  logic                          sweep_strobe,
  output class_t                        class_out,
  output logic                          class_valid,
  output logic                          class_changed,
  output logic                          low_conf,
  output logic [clog2(WINDOW+1)-1:0]    win_count
);

  localparam int CW = clog2(WINDOW + 1);

  // Reject out-of-range configurations at elaboration.
  if (WINDOW < 2 || WINDOW > 255) begin : g_bad_window
    $error("network_output_vote: WINDOW out of range");
  end
  if (MIN_VOTES < 1 || MIN_VOTES > WINDOW) begin : g_bad_min_votes
    $error("network_output_vote: MIN_VOTES out of range");
  end
  if (HOLD_WINDOWS < 1 || HOLD_WINDOWS > 15) begin : g_bad_hold
    $error("network_output_vote: HOLD_WINDOWS out of range");
  end

  vote_state_t                   r_state;
  logic [NUM_CLASSES-1:0][CW-1:0] r_vote;
  logic [CW-1:0]                 r_sweep_cnt;
  class_t                        r_class_out;
  logic                          r_class_valid;
  logic                          r_class_changed;
  logic                          r_low_conf;
  logic [CW-1:0]                 r_win_count;

  class_t                        w_win_idx;
  logic [CW-1:0]                 w_win_cnt;
  logic                          w_has_cand;

  vote_argmax #(
    .CW (CW)
  ) u_argmax (
    .i_vote  (r_vote),
    .o_idx   (w_win_idx),
    .o_count (w_win_cnt)
  );

  assign w_has_cand = (w_win_cnt >= CW'(MIN_VOTES));

`ifdef VOTE_HYST_EN
  logic [3:0] r_agree;
  class_t     r_pending;
  logic [3:0] w_next_agree;

  // A repeat of the pending class extends the streak; anything else restarts it.
  assign w_next_agree = (w_win_idx == r_pending) ? r_agree + 4'd1 : 4'd1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the vote counters are reset along with the control state, so a
      // reset mid-window really discards the partial votes.
      r_state         <= ACCUM;
      r_vote          <= '0;
      r_sweep_cnt     <= '0;
      r_class_out     <= '0;
      r_class_valid   <= 1'b0;
      r_class_changed <= 1'b0;
      r_low_conf      <= 1'b0;
      r_win_count     <= '0;
`ifdef VOTE_HYST_EN
      r_agree         <= '0;
      r_pending       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this
      // block override earlier defaults (pulses below, counter reload in DECIDE).
      r_class_valid   <= 1'b0;
      r_class_changed <= 1'b0;
      r_low_conf      <= 1'b0;

      case (r_state)
        ACCUM: begin
          if (sweep_strobe) begin
            r_vote[network_output] <= r_vote[network_output] + CW'(1);
            r_sweep_cnt            <= r_sweep_cnt + CW'(1);
            if (r_sweep_cnt == CW'(WINDOW - 1)) r_state <= DECIDE;
          end
        end

        DECIDE: begin
          r_class_valid <= 1'b1;
          r_win_count   <= w_win_cnt;
          r_low_conf    <= !w_has_cand;

          if (w_has_cand) begin
`ifdef VOTE_HYST_EN
            if (w_win_idx == r_class_out) begin
              r_agree <= '0;
            end else begin
              r_pending <= w_win_idx;
              if (w_next_agree >= 4'(HOLD_WINDOWS)) begin
                r_class_out     <= w_win_idx;
                r_class_changed <= 1'b1;
                r_agree         <= '0;
              end else begin
                r_agree <= w_next_agree;
              end
            end
`else
            r_class_out     <= w_win_idx;
            r_class_changed <= (w_win_idx != r_class_out);
`endif
          end
`ifdef VOTE_HYST_EN
          else begin
            r_agree <= '0;
          end
`endif

          // Start the next window; a strobe landing here is its first vote.
          r_vote      <= '0;
          r_sweep_cnt <= '0;
          if (sweep_strobe) begin
            r_vote[network_output] <= CW'(1);
            r_sweep_cnt            <= CW'(1);
          end
          r_state <= ACCUM;
        end

        default: r_state <= ACCUM;
      endcase
    end
  end

  assign class_out     = r_class_out;
  assign class_valid   = r_class_valid;
  assign class_changed = r_class_changed;
  assign low_conf      = r_low_conf;
  assign win_count     = r_win_count;

endmodule : network_output_vote
